// File: rtl/msk_hpc3o_sched_if.sv
// Bus bundle between the MSKand_hpc3o scheduler, its requesters, the PRNG and the gadget.
// The master side is the environment; the slave side is the scheduler.
interface msk_hpc3o_sched_if #(
  parameter int unsigned d    = 2,
  parameter int unsigned NREQ = 4
);
  localparam int unsigned RND_W = d * (d - 1);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*d-1:0] req_a;
  logic [NREQ*d-1:0] req_b;
  logic [RND_W-1:0]  rnd_in;
  logic              rnd_valid;
  logic              rnd_ready;
  logic [d-1:0]      g_ina;
  logic [d-1:0]      g_ina_prev;
  logic [d-1:0]      g_inb;
  logic [RND_W-1:0]  g_rnd;
  logic [d-1:0]      g_out;
  logic [NREQ-1:0]   rsp_valid;
  logic [d-1:0]      rsp_data;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b, rnd_in, rnd_valid, g_out,
    input  req_ready, rnd_ready, g_ina, g_ina_prev, g_inb, g_rnd,
           rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rnd_in, rnd_valid, g_out,
    output req_ready, rnd_ready, g_ina, g_ina_prev, g_inb, g_rnd,
           rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/msk_hpc3o_sched.sv
// Round-robin scheduler sharing one pipelined MSKand_hpc3o gadget between NREQ requesters.
// Two-stage pipeline: stage 1 tracks the issued op and feeds ina_prev, stage 2 holds the result.
module msk_hpc3o_sched #(
  parameter int unsigned d    = 2,
  parameter int unsigned NREQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  msk_hpc3o_sched_if.slave    bus
);
  localparam int unsigned RND_W = d * (d - 1);
  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_tag1;
  logic [d-1:0]     r_a_d;
  logic [d-1:0]     r_res;
  logic             r_v1;
  logic             r_v2;
  logic [NREQ-1:0]  r_rsp_valid;

  logic [IDX_W-1:0] w_gnt;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic             w_any;
  logic             w_issue;
  logic [NREQ-1:0]  w_onehot;
  logic [NREQ-1:0]  w_tag1_oh;
  logic [d-1:0]     w_ina;
  logic [d-1:0]     w_inb;

  // Round-robin: first valid at or above ptr, otherwise first valid from index 0.
  always_comb begin : rr_grant
    w_gnt = '0;
    w_any = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_any && bus.req_valid[i] && (IDX_W'(i) >= r_ptr)) begin
        w_any = 1'b1;
        w_gnt = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_any && bus.req_valid[i]) begin
        w_any = 1'b1;
        w_gnt = IDX_W'(i);
      end
    end
  end

  assign w_issue   = !rst && bus.rnd_valid && w_any;
  assign w_ptr_nxt = (w_gnt == IDX_W'(NREQ - 1)) ? '0 : w_gnt + IDX_W'(1);

  // AND-gated operand mux so unselected shares never toggle the gadget inputs.
  always_comb begin : operand_mux
    w_onehot  = '0;
    w_tag1_oh = '0;
    w_ina     = '0;
    w_inb     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_onehot[i]  = w_issue && (w_gnt == IDX_W'(i));
      w_tag1_oh[i] = r_v1 && (r_tag1 == IDX_W'(i));
      w_ina        = w_ina | (bus.req_a[i*d +: d] & {d{w_onehot[i]}});
      w_inb        = w_inb | (bus.req_b[i*d +: d] & {d{w_onehot[i]}});
    end
  end

  always_ff @(posedge clk) begin : pipe
    if (rst) begin
      r_ptr       <= '0;
      r_a_d       <= '0;
      r_v1        <= 1'b0;
      r_tag1      <= '0;
      r_res       <= '0;
      r_v2        <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      if (w_issue) begin
        r_ptr <= w_ptr_nxt;
      end
      r_a_d       <= w_ina;
      r_v1        <= w_issue;
      r_tag1      <= w_gnt;
      r_res       <= r_v1 ? bus.g_out : '0;
      r_v2        <= r_v1;
      r_rsp_valid <= w_tag1_oh;
    end
  end

  assign bus.req_ready  = w_onehot;
  assign bus.rnd_ready  = w_issue;
  assign bus.g_ina      = w_ina;
  assign bus.g_inb      = w_inb;
  assign bus.g_rnd      = w_issue ? bus.rnd_in : RND_W'(0);
  assign bus.g_ina_prev = r_a_d;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_res;
  assign bus.busy       = r_v1 | r_v2;
endmodule
